// File: rtl/roic_frame_sequencer.sv
// -----------------------------------------------------------------------------
// roic_frame_sequencer
//
// Frame-level controller for the ROIC pixel array. One frame is a global pixel
// reset, an integration period, and a raster scan over a programmable window.
// Each scanned pixel goes to the column ADC through a conv_req/conv_ack
// handshake. Row and column are driven as binary addresses; the external
// decoders turn them into one-hot enables.
//
// Ports
//   clk_i             system clock, rising edge
//   rst_n_i           synchronous active-low reset
//   start_i           frame start request, only looked at in IDLE
//   abort_i           abandon the current frame
//   int_time_i        integration length in cycles (0 behaves as 1)
//   win_row_start_i   first window row
//   win_row_end_i     last window row, inclusive
//   win_col_start_i   first window column
//   win_col_end_i     last window column, inclusive
//   conv_ack_i        ADC accepts the current pixel
//   pix_rst_o         global pixel reset
//   integ_o           integration active
//   row_sel_o         row drivers enabled
//   row_addr_o        selected row
//   col_addr_o        selected column
//   conv_req_o        conversion request for (row_addr_o, col_addr_o)
//   last_pix_o        marks conv_req_o on the final pixel of the window
//   busy_o            high whenever not IDLE
//   frame_done_o      one-cycle pulse when a frame completes
//   cfg_err_o         sticky illegal-window flag, cleared by an accepted start
// -----------------------------------------------------------------------------
module roic_frame_sequencer #(
    parameter int COLS       = 640,
    parameter int ROWS       = 512,
    parameter int RST_CYC    = 4,
    parameter int ROW_SETTLE = 2,
    parameter int INT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [INT_W-1:0] int_time_i,
    input  logic [8:0]       win_row_start_i,
    input  logic [8:0]       win_row_end_i,
    input  logic [9:0]       win_col_start_i,
    input  logic [9:0]       win_col_end_i,
    input  logic             conv_ack_i,
    output logic             pix_rst_o,
    output logic             integ_o,
    output logic             row_sel_o,
    output logic [8:0]       row_addr_o,
    output logic [9:0]       col_addr_o,
    output logic             conv_req_o,
    output logic             last_pix_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             cfg_err_o
);

    localparam int RCW = $clog2(RST_CYC + 1);
    localparam int SCW = $clog2(ROW_SETTLE + 1);

    localparam logic [RCW-1:0]   RST_LAST    = RCW'(RST_CYC - 1);
    localparam logic [RCW-1:0]   RST_ONE     = RCW'(1);
    localparam logic [SCW-1:0]   SETTLE_LAST = SCW'(ROW_SETTLE - 1);
    localparam logic [SCW-1:0]   SETTLE_ONE  = SCW'(1);
    localparam logic [INT_W-1:0] INT_ONE     = INT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        PIX_RESET,
        INTEGRATE,
        ROW_SEL,
        COL_SCAN,
        FRAME_END
    } state_e;

    state_e             state_q, state_d;
    logic [RCW-1:0]     rst_cnt_q, rst_cnt_d;
    logic [SCW-1:0]     settle_cnt_q, settle_cnt_d;
    logic [INT_W-1:0]   int_cnt_q, int_cnt_d;
    logic [8:0]         row_q, row_d;
    logic [9:0]         col_q, col_d;
    logic [8:0]         row_start_q, row_start_d;
    logic [8:0]         row_end_q, row_end_d;
    logic [9:0]         col_start_q, col_start_d;
    logic [9:0]         col_end_q, col_end_d;
    logic               cfg_err_q, cfg_err_d;
    logic               win_illegal;

    logic pix_rst_q, integ_q, row_sel_q, conv_req_q, last_pix_q, busy_q, frame_done_q;

    // Window bounds are widened before comparing against the array size so
    // that an end coordinate equal to ROWS/COLS is caught even when the port
    // width could carry it.
    assign win_illegal = (win_row_start_i > win_row_end_i)
                      || (win_col_start_i > win_col_end_i)
                      || (32'(win_row_end_i) >= 32'(ROWS))
                      || (32'(win_col_end_i) >= 32'(COLS));

    // Next-state logic. The integration counter is loaded with max(int_time,1)
    // at start and counts down, so a zero request still gives one cycle.
    // Abort is applied last so it overrides every transition, including a
    // transfer on the same cycle.
    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        settle_cnt_d = settle_cnt_q;
        int_cnt_d    = int_cnt_q;
        row_d        = row_q;
        col_d        = col_q;
        row_start_d  = row_start_q;
        row_end_d    = row_end_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        cfg_err_d    = cfg_err_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (win_illegal) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_err_d   = 1'b0;
                        row_start_d = win_row_start_i;
                        row_end_d   = win_row_end_i;
                        col_start_d = win_col_start_i;
                        col_end_d   = win_col_end_i;
                        int_cnt_d   = (int_time_i == '0) ? INT_ONE : int_time_i;
                        rst_cnt_d   = '0;
                        state_d     = PIX_RESET;
                    end
                end
            end
            PIX_RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = INTEGRATE;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_ONE;
                end
            end
            INTEGRATE: begin
                if (int_cnt_q <= INT_ONE) begin
                    state_d      = ROW_SEL;
                    row_d        = row_start_q;
                    col_d        = col_start_q;
                    settle_cnt_d = '0;
                end else begin
                    int_cnt_d = int_cnt_q - INT_ONE;
                end
            end
            ROW_SEL: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = COL_SCAN;
                end else begin
                    settle_cnt_d = settle_cnt_q + SETTLE_ONE;
                end
            end
            COL_SCAN: begin
                if (conv_ack_i) begin
                    if (col_q != col_end_q) begin
                        col_d = col_q + 10'd1;
                    end else if (row_q != row_end_q) begin
                        row_d        = row_q + 9'd1;
                        col_d        = col_start_q;
                        settle_cnt_d = '0;
                        state_d      = ROW_SEL;
                    end else begin
                        state_d = FRAME_END;
                    end
                end
            end
            FRAME_END: begin
                state_d = IDLE;
                row_d   = '0;
                col_d   = '0;
            end
            default: begin
                state_d = IDLE;
                row_d   = '0;
                col_d   = '0;
            end
        endcase

        if (state_q != IDLE && abort_i) begin
            state_d = IDLE;
            row_d   = '0;
            col_d   = '0;
        end
    end

    // State, counters and registered Moore outputs. Outputs are decoded from
    // the next state so they line up with the state they describe.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            rst_cnt_q    <= '0;
            settle_cnt_q <= '0;
            int_cnt_q    <= '0;
            row_q        <= '0;
            col_q        <= '0;
            row_start_q  <= '0;
            row_end_q    <= '0;
            col_start_q  <= '0;
            col_end_q    <= '0;
            cfg_err_q    <= 1'b0;
            pix_rst_q    <= 1'b0;
            integ_q      <= 1'b0;
            row_sel_q    <= 1'b0;
            conv_req_q   <= 1'b0;
            last_pix_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            int_cnt_q    <= int_cnt_d;
            row_q        <= row_d;
            col_q        <= col_d;
            row_start_q  <= row_start_d;
            row_end_q    <= row_end_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            cfg_err_q    <= cfg_err_d;
            pix_rst_q    <= (state_d == PIX_RESET);
            integ_q      <= (state_d == INTEGRATE);
            row_sel_q    <= (state_d == ROW_SEL) || (state_d == COL_SCAN);
            conv_req_q   <= (state_d == COL_SCAN);
            last_pix_q   <= (state_d == COL_SCAN) && (row_d == row_end_d) && (col_d == col_end_d);
            busy_q       <= (state_d != IDLE);
            frame_done_q <= (state_d == FRAME_END);
        end
    end

    assign pix_rst_o    = pix_rst_q;
    assign integ_o      = integ_q;
    assign row_sel_o    = row_sel_q;
    assign row_addr_o   = row_q;
    assign col_addr_o   = col_q;
    assign conv_req_o   = conv_req_q;
    assign last_pix_o   = last_pix_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
    assign cfg_err_o    = cfg_err_q;

endmodule

// File: tb/tb_roic_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_roic_frame_sequencer
//
// Directed bench for roic_frame_sequencer with RST_CYC=2, ROW_SETTLE=1.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Cycle numbers are counted from the cycle in which start is
// high (cycle 0). A negedge monitor logs every handshake transfer, every
// frame_done pulse and every last_pix/integ cycle; scenario tasks compare
// those logs and sampled outputs against hand-derived timelines.
// -----------------------------------------------------------------------------
module tb_roic_frame_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] int_time;
    logic [8:0]  win_row_start, win_row_end;
    logic [9:0]  win_col_start, win_col_end;
    logic        conv_ack;
    logic        pix_rst, integ, row_sel, conv_req, last_pix, busy, frame_done, cfg_err;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int t0     = 0;

    // Monitor logs
    int         nx, ndone, tdone, nlast, ninteg;
    logic [8:0] xr [2048];
    logic [9:0] xc [2048];
    logic       xl [2048];
    int         xt [2048];

    roic_frame_sequencer #(
        .COLS(640), .ROWS(512), .RST_CYC(2), .ROW_SETTLE(1), .INT_W(16)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort),
        .int_time_i(int_time),
        .win_row_start_i(win_row_start), .win_row_end_i(win_row_end),
        .win_col_start_i(win_col_start), .win_col_end_i(win_col_end),
        .conv_ack_i(conv_ack),
        .pix_rst_o(pix_rst), .integ_o(integ), .row_sel_o(row_sel),
        .row_addr_o(row_addr), .col_addr_o(col_addr),
        .conv_req_o(conv_req), .last_pix_o(last_pix), .busy_o(busy),
        .frame_done_o(frame_done), .cfg_err_o(cfg_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // A transfer is logged when the handshake is valid just before the edge
    // that takes it (abort and reset cancel it).
    always @(negedge clk) begin
        if (rst_n && conv_req && conv_ack && !abort) begin
            if (nx < 2048) begin
                xr[nx] = row_addr;
                xc[nx] = col_addr;
                xl[nx] = last_pix;
                xt[nx] = cyc - t0;
            end
            nx++;
        end
        if (frame_done) begin
            ndone++;
            tdone = cyc - t0;
        end
        if (last_pix) nlast++;
        if (integ) ninteg++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        nx = 0; ndone = 0; tdone = -1; nlast = 0; ninteg = 0;
    endtask

    task automatic set_window(input int rs, input int re, input int cs, input int ce, input int it);
        win_row_start = 9'(rs);
        win_row_end   = 9'(re);
        win_col_start = 10'(cs);
        win_col_end   = 10'(ce);
        int_time      = 16'(it);
    endtask

    // Bounded wait for IDLE; an expired bound is reported as a failure.
    task automatic wait_idle(input string name);
        for (int k = 0; k < 2000 && busy; k++) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s_idle_timeout: got busy=%b expected 0", name, busy); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; conv_ack = 1'b0;
        set_window(0, 0, 0, 0, 0);
        repeat (3) tick();
        @(negedge clk);
        checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (pix_rst !== 1'b0)  begin errors++; $display("[TB] FAIL reset_pix_rst: got %b expected 0", pix_rst); end
        checks++; if (conv_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_conv_req: got %b expected 0", conv_req); end
        checks++; if (cfg_err !== 1'b0)  begin errors++; $display("[TB] FAIL reset_cfg_err: got %b expected 0", cfg_err); end
        checks++; if (row_addr !== 9'd0 || col_addr !== 10'd0) begin errors++; $display("[TB] FAIL reset_addr: got (%0d,%0d) expected (0,0)", row_addr, col_addr); end
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    // Nominal frame, ack tied high. Optionally pulses start while busy to
    // confirm the extra requests do not disturb timing.
    task automatic test_basic(input bit restart_while_busy, input string name);
        int er [6];
        int ec [6];
        int et [6];
        er = '{5, 5, 5, 6, 6, 6};
        ec = '{10, 11, 12, 10, 11, 12};
        et = '{8, 9, 10, 12, 13, 14};
        set_window(5, 6, 10, 12, 4);
        conv_ack = 1'b1;
        tick(); start = 1'b1; t0 = cyc; clear_logs();
        for (int r = 0; r <= 17; r++) begin
            @(negedge clk);
            checks++; if (pix_rst !== (r >= 1 && r <= 2)) begin errors++; $display("[TB] FAIL %s_pix_rst c%0d: got %b expected %b", name, r, pix_rst, (r >= 1 && r <= 2)); end
            checks++; if (integ !== (r >= 3 && r <= 6))   begin errors++; $display("[TB] FAIL %s_integ c%0d: got %b expected %b", name, r, integ, (r >= 3 && r <= 6)); end
            checks++; if (busy !== (r >= 1 && r <= 15))   begin errors++; $display("[TB] FAIL %s_busy c%0d: got %b expected %b", name, r, busy, (r >= 1 && r <= 15)); end
            checks++; if (row_sel !== (r >= 7 && r <= 14)) begin errors++; $display("[TB] FAIL %s_row_sel c%0d: got %b expected %b", name, r, row_sel, (r >= 7 && r <= 14)); end
            tick();
            start = restart_while_busy && ((r + 1) == 5 || (r + 1) == 9);
        end
        start = 1'b0;
        checks++; if (nx !== 6) begin errors++; $display("[TB] FAIL %s_xfer_count: got %0d expected 6", name, nx); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (xr[i] !== 9'(er[i]) || xc[i] !== 10'(ec[i]) || xt[i] !== et[i] || xl[i] !== (i == 5)) begin
                errors++;
                $display("[TB] FAIL %s_xfer%0d: got (%0d,%0d) c%0d last=%b expected (%0d,%0d) c%0d last=%b",
                         name, i, xr[i], xc[i], xt[i], xl[i], er[i], ec[i], et[i], (i == 5));
            end
        end
        checks++; if (ndone !== 1 || tdone !== 15) begin errors++; $display("[TB] FAIL %s_frame_done: got %0d pulses at c%0d expected 1 at c15", name, ndone, tdone); end
        checks++; if (nlast !== 1) begin errors++; $display("[TB] FAIL %s_last_pix_cycles: got %0d expected 1", name, nlast); end
        checks++; if (row_addr !== 9'd0 || col_addr !== 10'd0) begin errors++; $display("[TB] FAIL %s_addr_return: got (%0d,%0d) expected (0,0)", name, row_addr, col_addr); end
    endtask

    // Each pixel sees three cycles of ack low before the ack.
    task automatic test_stall();
        int w;
        int et [6];
        et = '{11, 15, 19, 24, 28, 32};
        w = 0;
        set_window(5, 6, 10, 12, 4);
        conv_ack = 1'b0;
        tick(); start = 1'b1; t0 = cyc; clear_logs();
        for (int r = 0; r <= 35; r++) begin
            @(negedge clk);
            if (r == 9 || r == 13) begin
                checks++;
                if (conv_req !== 1'b1 || row_addr !== 9'd5 || col_addr !== ((r == 9) ? 10'd10 : 10'd11)) begin
                    errors++;
                    $display("[TB] FAIL stall_hold c%0d: got req=%b (%0d,%0d) expected req=1 (5,%0d)", r, conv_req, row_addr, col_addr, (r == 9) ? 10 : 11);
                end
            end
            if (r == 30) begin
                checks++;
                if (conv_req !== 1'b1 || last_pix !== 1'b1 || row_addr !== 9'd6 || col_addr !== 10'd12) begin
                    errors++;
                    $display("[TB] FAIL stall_last c30: got req=%b last=%b (%0d,%0d) expected req=1 last=1 (6,12)", conv_req, last_pix, row_addr, col_addr);
                end
            end
            tick();
            start = 1'b0;
            if (conv_req) begin
                conv_ack = (w == 3);
                w = (w == 3) ? 0 : w + 1;
            end else begin
                conv_ack = 1'b0;
                w = 0;
            end
        end
        conv_ack = 1'b0;
        checks++; if (nx !== 6) begin errors++; $display("[TB] FAIL stall_xfer_count: got %0d expected 6", nx); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (xt[i] !== et[i]) begin errors++; $display("[TB] FAIL stall_xfer%0d_cycle: got c%0d expected c%0d", i, xt[i], et[i]); end
        end
        checks++; if (ndone !== 1 || tdone !== 33) begin errors++; $display("[TB] FAIL stall_frame_done: got %0d pulses at c%0d expected 1 at c33", ndone, tdone); end
        checks++; if (nlast !== 4) begin errors++; $display("[TB] FAIL stall_last_pix_cycles: got %0d expected 4", nlast); end
    endtask

    // int_time=0 with the single-pixel window (3,3).
    task automatic test_single_pixel();
        set_window(3, 3, 3, 3, 0);
        conv_ack = 1'b1;
        tick(); start = 1'b1; t0 = cyc; clear_logs();
        for (int r = 0; r <= 9; r++) begin
            tick();
            start = 1'b0;
        end
        checks++; if (ninteg !== 1) begin errors++; $display("[TB] FAIL single_integ_cycles: got %0d expected 1", ninteg); end
        checks++; if (nx !== 1) begin errors++; $display("[TB] FAIL single_xfer_count: got %0d expected 1", nx); end
        checks++;
        if (xr[0] !== 9'd3 || xc[0] !== 10'd3 || xl[0] !== 1'b1 || xt[0] !== 5) begin
            errors++;
            $display("[TB] FAIL single_xfer: got (%0d,%0d) last=%b c%0d expected (3,3) last=1 c5", xr[0], xc[0], xl[0], xt[0]);
        end
        checks++; if (ndone !== 1 || tdone !== 6) begin errors++; $display("[TB] FAIL single_frame_done: got %0d pulses at c%0d expected 1 at c6", ndone, tdone); end
    endtask

    // Two full-width rows at the bottom edge of the array.
    task automatic test_wide_rows();
        set_window(510, 511, 0, 639, 1);
        conv_ack = 1'b1;
        tick(); start = 1'b1; t0 = cyc; clear_logs();
        for (int r = 0; r <= 1290; r++) begin
            tick();
            start = 1'b0;
        end
        checks++; if (nx !== 1280) begin errors++; $display("[TB] FAIL wide_xfer_count: got %0d expected 1280", nx); end
        checks++; if (xr[0] !== 9'd510 || xc[0] !== 10'd0 || xt[0] !== 5) begin errors++; $display("[TB] FAIL wide_first: got (%0d,%0d) c%0d expected (510,0) c5", xr[0], xc[0], xt[0]); end
        checks++; if (xr[639] !== 9'd510 || xc[639] !== 10'd639 || xl[639] !== 1'b0 || xt[639] !== 644) begin errors++; $display("[TB] FAIL wide_row_end: got (%0d,%0d) last=%b c%0d expected (510,639) last=0 c644", xr[639], xc[639], xl[639], xt[639]); end
        checks++; if (xr[640] !== 9'd511 || xc[640] !== 10'd0 || xt[640] !== 646) begin errors++; $display("[TB] FAIL wide_next_row: got (%0d,%0d) c%0d expected (511,0) c646", xr[640], xc[640], xt[640]); end
        checks++; if (xr[1279] !== 9'd511 || xc[1279] !== 10'd639 || xl[1279] !== 1'b1 || xt[1279] !== 1285) begin errors++; $display("[TB] FAIL wide_last: got (%0d,%0d) last=%b c%0d expected (511,639) last=1 c1285", xr[1279], xc[1279], xl[1279], xt[1279]); end
        checks++; if (ndone !== 1 || tdone !== 1286) begin errors++; $display("[TB] FAIL wide_frame_done: got %0d pulses at c%0d expected 1 at c1286", ndone, tdone); end
        checks++; if (nlast !== 1) begin errors++; $display("[TB] FAIL wide_last_pix_cycles: got %0d expected 1", nlast); end
    endtask

    task automatic test_illegal();
        conv_ack = 1'b1;
        set_window(5, 6, 10, 640, 2);
        tick(); start = 1'b1; tick(); start = 1'b0;
        @(negedge clk);
        checks++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL illegal_col: got cfg_err=%b busy=%b expected 1 0", cfg_err, busy); end
        repeat (3) tick();
        @(negedge clk);
        checks++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL illegal_sticky: got cfg_err=%b busy=%b expected 1 0", cfg_err, busy); end
        set_window(5, 6, 10, 12, 2);
        tick(); start = 1'b1; t0 = cyc; clear_logs(); tick(); start = 1'b0;
        @(negedge clk);
        checks++; if (cfg_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL illegal_clear: got cfg_err=%b busy=%b expected 0 1", cfg_err, busy); end
        wait_idle("illegal_run1");
        checks++; if (ndone !== 1 || nx !== 6) begin errors++; $display("[TB] FAIL illegal_run1: got %0d done %0d xfers expected 1 done 6 xfers", ndone, nx); end
        set_window(7, 3, 10, 12, 2);
        tick(); start = 1'b1; tick(); start = 1'b0;
        @(negedge clk);
        checks++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL illegal_row: got cfg_err=%b busy=%b expected 1 0", cfg_err, busy); end
        set_window(3, 3, 3, 3, 1);
        tick(); start = 1'b1; t0 = cyc; clear_logs(); tick(); start = 1'b0;
        @(negedge clk);
        checks++; if (cfg_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL illegal_clear2: got cfg_err=%b busy=%b expected 0 1", cfg_err, busy); end
        wait_idle("illegal_run2");
        checks++; if (ndone !== 1 || nx !== 1) begin errors++; $display("[TB] FAIL illegal_run2: got %0d done %0d xfers expected 1 done 1 xfer", ndone, nx); end
    endtask

    // abort during INTEGRATE (cycle 4), then abort together with ack in
    // COL_SCAN (cycle 9, second pixel of the first row).
    task automatic test_abort();
        set_window(5, 6, 10, 12, 4);
        conv_ack = 1'b1;
        tick(); start = 1'b1; t0 = cyc; clear_logs();
        for (int r = 0; r <= 12; r++) begin
            @(negedge clk);
            if (r == 4) begin
                checks++; if (integ !== 1'b1) begin errors++; $display("[TB] FAIL abort_int_pre: got integ=%b expected 1", integ); end
            end
            if (r >= 5) begin
                checks++; if (busy !== 1'b0 || integ !== 1'b0) begin errors++; $display("[TB] FAIL abort_int c%0d: got busy=%b integ=%b expected 0 0", r, busy, integ); end
            end
            tick();
            start = 1'b0;
            abort = ((r + 1) == 4);
        end
        checks++; if (ndone !== 0 || nx !== 0) begin errors++; $display("[TB] FAIL abort_int_log: got %0d done %0d xfers expected 0 0", ndone, nx); end

        tick(); start = 1'b1; t0 = cyc; clear_logs();
        for (int r = 0; r <= 14; r++) begin
            @(negedge clk);
            if (r == 10) begin
                checks++;
                if (busy !== 1'b0 || conv_req !== 1'b0 || row_sel !== 1'b0 || row_addr !== 9'd0 || col_addr !== 10'd0) begin
                    errors++;
                    $display("[TB] FAIL abort_scan c10: got busy=%b req=%b rsel=%b (%0d,%0d) expected 0 0 0 (0,0)", busy, conv_req, row_sel, row_addr, col_addr);
                end
            end
            tick();
            start = 1'b0;
            abort = ((r + 1) == 9);
        end
        checks++; if (ndone !== 0 || nx !== 1 || xc[0] !== 10'd10) begin errors++; $display("[TB] FAIL abort_scan_log: got %0d done %0d xfers col0=%0d expected 0 done 1 xfer col0=10", ndone, nx, xc[0]); end
    endtask

    // rst_n low for cycle 9 while scanning; everything is 0 in cycle 10.
    task automatic test_reset_mid_scan();
        set_window(5, 6, 10, 12, 4);
        conv_ack = 1'b1;
        tick(); start = 1'b1; t0 = cyc; clear_logs();
        for (int r = 0; r <= 14; r++) begin
            @(negedge clk);
            if (r == 10) begin
                checks++;
                if ({pix_rst, integ, row_sel, conv_req, last_pix, busy, frame_done, cfg_err} !== 8'd0 ||
                    row_addr !== 9'd0 || col_addr !== 10'd0) begin
                    errors++;
                    $display("[TB] FAIL rst_mid_scan c10: got flags=%b (%0d,%0d) expected 00000000 (0,0)",
                             {pix_rst, integ, row_sel, conv_req, last_pix, busy, frame_done, cfg_err}, row_addr, col_addr);
                end
            end
            if (r == 8) begin
                checks++; if (conv_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_scan_pre: got req=%b expected 1", conv_req); end
            end
            tick();
            start = 1'b0;
            rst_n = ((r + 1) != 9);
        end
        checks++; if (ndone !== 0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_scan_after: got %0d done busy=%b expected 0 0", ndone, busy); end
    endtask

    initial begin
        test_reset();
        test_basic(1'b0, "basic");
        test_stall();
        test_single_pixel();
        test_wide_rows();
        test_illegal();
        test_abort();
        test_reset_mid_scan();
        test_basic(1'b1, "restart_busy");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/roic_frame_sequencer.md
Name: roic_frame_sequencer

Overview:
- Frame-level controller for the 640x512 ROIC pixel array.
- Runs pixel reset, then integration, then a row/column scan over a programmable window (ROI).
- Each scanned pixel is handed to the column ADC through a req/ack handshake.
- Drives binary row/column addresses; downstream decoders produce the one-hot row_enable/col_enable.

Parameters:
- COLS, 640, number of array columns.
- ROWS, 512, number of array rows.
- RST_CYC, 4, cycles pix_rst is held high per frame (>=1).
- ROW_SETTLE, 2, settle cycles after each new row select before the first conversion request (>=1).
- INT_W, 16, width of the integration-time field.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  frame start request; sampled only in IDLE.
- abort  input  1  abandon the current frame.
- int_time  input  INT_W  integration length in cycles; latched at start; 0 is treated as 1.
- win_row_start  input  9  first row of the window; latched at start.
- win_row_end  input  9  last row of the window, inclusive; latched at start.
- win_col_start  input  10  first column of the window; latched at start.
- win_col_end  input  10  last column of the window, inclusive; latched at start.
- conv_ack  input  1  ADC accepts the current pixel.
- pix_rst  output  1  global pixel reset.
- integ  output  1  integration window active.
- row_sel  output  1  row drivers enabled.
- row_addr  output  9  selected row.
- col_addr  output  10  selected column.
- conv_req  output  1  conversion request for pixel (row_addr, col_addr).
- last_pix  output  1  qualifies conv_req on the final pixel of the window.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse on frame completion.
- cfg_err  output  1  sticky; set by an illegal window, cleared by the next accepted start.

Behaviour:
- Reset: rst_n low at a rising edge forces state IDLE, zeroes all counters, and drives every output to 0. This applies at any point mid-frame; no frame_done is issued.
- Outputs are Moore decodes of state plus address registers. There are no combinational paths from inputs to outputs, except that conv_req deasserts based only on state.
- IDLE, start=1:
  - If the window is legal, latch config, clear cfg_err, next state PIX_RESET.
  - Illegal window: win_row_start>win_row_end, win_col_start>win_col_end, win_row_end>=ROWS, or win_col_end>=COLS. In that case set cfg_err and stay in IDLE.
- PIX_RESET: pix_rst=1 for exactly RST_CYC cycles, then INTEGRATE.
- INTEGRATE: integ=1 for exactly max(int_time,1) cycles, then ROW_SEL with row_addr=win_row_start.
- ROW_SEL:
  - row_sel=1 for ROW_SETTLE cycles; col_addr=win_col_start.
  - Then COL_SCAN.
- COL_SCAN: row_sel=1 and conv_req=1.
  - row_addr and col_addr hold stable until conv_ack=1 at a rising edge (transfer). conv_ack while conv_req=0 is ignored.
  - On transfer with col_addr<win_col_end: col_addr+1, stay in COL_SCAN. conv_req stays high, so back-to-back transfers give 1 pixel/cycle.
  - On transfer with col_addr==win_col_end and row_addr<win_row_end: row_addr+1, next state ROW_SEL. row_sel stays high and settling re-runs for the new row.
  - On transfer at the last pixel: next state FRAME_END.
  - last_pix=1 while conv_req=1 at (win_row_end, win_col_end).
- FRAME_END: frame_done=1 for one cycle, then IDLE; row_addr and col_addr return to 0.
- abort=1 in any non-IDLE state: next state IDLE, no frame_done. An in-flight conv_req is dropped, even if conv_ack is high the same cycle. abort takes priority over all transitions; rst_n takes priority over abort.
- start outside IDLE is ignored. Config inputs change freely after start without effect.
- Single-pixel window (start==end on both axes) is legal: exactly one transfer, with last_pix=1.
- Counters are sized to INT_W, clog2(RST_CYC+1) and clog2(ROW_SETTLE+1). Address arithmetic never wraps because window legality is checked at start.

Test Plan:
- Defaults with RST_CYC=2, ROW_SETTLE=1, window rows 5..6 / cols 10..12, int_time=4, conv_ack tied 1, start pulsed in cycle 0:
  - pix_rst in cycles 1-2, integ in cycles 3-6.
  - Transfers (5,10),(5,11),(5,12) in cycles 8-10 and (6,10),(6,11),(6,12) in cycles 12-14.
  - frame_done in cycle 15; last_pix only in cycle 14.
- Same window with conv_ack low for 3 cycles on each pixel: addresses hold stable while conv_req is high, 6 transfers total, frame_done in cycle 33.
- int_time=0 -> integ high for exactly 1 cycle. Full-array window 0..511 / 0..639 with ack tied 1 -> 327680 transfers, last transfer (511,639) with last_pix.
- Illegal window (win_col_end=640, or win_row_start=7 > win_row_end=3) -> cfg_err=1, busy stays 0. A following legal start clears cfg_err and runs normally.
- abort in INTEGRATE, and abort coincident with conv_ack in COL_SCAN -> IDLE next cycle, no frame_done, no transfer counted; rst_n low mid-COL_SCAN -> all outputs 0 next cycle.
- start pulsed while busy -> ignored, frame timing unchanged. Single-pixel window (3,3) -> one transfer with last_pix=1, then frame_done.
